// File: rtl/half_pow2_arbiter.sv
// half_pow2_arbiter: round-robin front end sharing one half-precision
// 2^int(a) unit between NREQ requesters, with tag-steered responses.
module half_pow2_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    localparam int TW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [16*NREQ-1:0]   rsp_c,
    output logic                 unit_in_valid,
    output logic [15:0]          unit_a,
    input  logic                 unit_out_valid,
    input  logic [15:0]          unit_c,
    output logic                 err
);

    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [TW-1:0]   rr_ptr;
    logic [TW-1:0]   gidx;
    logic [TW-1:0]   idx_c;
    int              sum_c;

    logic            stg_v [LAT];
    logic [TW-1:0]   stg_t [LAT];
    logic            tail_v;
    logic [TW-1:0]   tail_t;
    logic            cap;

    assign elig          = req_valid & ~busy;
    assign req_ready     = grant;
    assign unit_in_valid = |grant;
    assign tail_v        = stg_v[LAT-1];
    assign tail_t        = stg_t[LAT-1];
    assign cap           = tail_v & unit_out_valid;

    // Round-robin pick: the eligible requester nearest above rr_ptr wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        sum_c = 0;
        idx_c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_c = int'(rr_ptr) + k;
            if (sum_c >= NREQ)
                sum_c = sum_c - NREQ;
            idx_c = TW'(sum_c);
            if (elig[idx_c]) begin
                grant        = '0;
                grant[idx_c] = 1'b1;
                gidx         = idx_c;
            end
        end
    end

    // Operand mux toward the shared unit; zero when nothing issues.
    always_comb begin
        unit_a = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                unit_a = req_a[16*i +: 16];
    end

    // Pointer moves just past the last winner so it goes to the back.
    always_ff @(posedge clk) begin
        if (!rstn)
            rr_ptr <= '0;
        else if (|grant)
            rr_ptr <= (gidx == TW'(NREQ - 1)) ? '0 : gidx + TW'(1);
    end

    // Tag shadow of the unit pipeline; the tail lines up with unit_out_valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) begin
                stg_v[k] <= 1'b0;
                stg_t[k] <= '0;
            end
        end else begin
            stg_v[0] <= |grant;
            stg_t[0] <= gidx;
            for (int k = 1; k < LAT; k++) begin
                stg_v[k] <= stg_v[k-1];
                stg_t[k] <= stg_t[k-1];
            end
        end
    end

    // Busy tracks one outstanding op per requester until its result is taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i])
                    busy[i] <= 1'b1;
                else if (rsp_valid[i] && rsp_ready[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    // Steer unit results into the tagged response slot; hold until accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_c     <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cap && tail_t == TW'(i)) begin
                    rsp_valid[i]      <= 1'b1;
                    rsp_c[16*i +: 16] <= unit_c;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky flag for a unit result that disagrees with the tag shadow.
    always_ff @(posedge clk) begin
        if (!rstn)
            err <= 1'b0;
        else if (tail_v != unit_out_valid)
            err <= 1'b1;
    end

endmodule
